// File: rtl/regfile_wb_if.sv
// Writeback-side signals between the EX/LSU pipeline, the register file
// and decode (forwarding / pending lookups).
interface regfile_wb_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ex_valid_i;
    logic                  ex_ready_o;
    logic [4:0]            ex_waddr_i;
    logic [DATA_WIDTH-1:0] ex_wdata_i;
    logic                  lsu_valid_i;
    logic [4:0]            lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;
    logic                  lsu_issue_i;
    logic [4:0]            lsu_issue_waddr_i;
    logic                  we_a_o;
    logic [4:0]            waddr_a_o;
    logic [DATA_WIDTH-1:0] wdata_a_o;
    logic [4:0]            raddr_a_i;
    logic [4:0]            raddr_b_i;
    logic                  fwd_hit_a_o;
    logic                  fwd_hit_b_o;
    logic [DATA_WIDTH-1:0] fwd_data_a_o;
    logic [DATA_WIDTH-1:0] fwd_data_b_o;
    logic                  pend_a_o;
    logic                  pend_b_o;
    logic                  protocol_err_o;

    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  lsu_issue_i, lsu_issue_waddr_i,
        input  raddr_a_i, raddr_b_i,
        output ex_ready_o, we_a_o, waddr_a_o, wdata_a_o,
        output fwd_hit_a_o, fwd_hit_b_o, fwd_data_a_o, fwd_data_b_o,
        output pend_a_o, pend_b_o, protocol_err_o
    );

    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output lsu_issue_i, lsu_issue_waddr_i,
        output raddr_a_i, raddr_b_i,
        input  ex_ready_o, we_a_o, waddr_a_o, wdata_a_o,
        input  fwd_hit_a_o, fwd_hit_b_o, fwd_data_a_o, fwd_data_b_o,
        input  pend_a_o, pend_b_o, protocol_err_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single register-file write port shared by LSU load returns and buffered EX
// results, with a load scoreboard and forwarding out of the write buffer.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk_int,
    input  logic         rst_n,
    regfile_wb_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [4:0]            addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    wr_t                   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [31:0]           pend_q, pend_set, pend_clr, pend_nxt;
    logic                  err_q;
    logic                  we_q;
    logic [4:0]            waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  fifo_full, fifo_empty, ex_ready;
    logic                  ex_acc, lsu_win, head_win, ex_win, enq, deq;
    logic                  win_we;
    wr_t                   win;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    // Ready looks only at the registered count, so a draining full FIFO stays not-ready.
    assign ex_ready   = rst_n && !fifo_full && !pend_q[bus.ex_waddr_i];
    assign ex_acc     = bus.ex_valid_i && ex_ready;

    assign lsu_win  = bus.lsu_valid_i && (bus.lsu_waddr_i != 5'd0);
    assign head_win = !lsu_win && !fifo_empty;
    assign ex_win   = !lsu_win && fifo_empty && ex_acc && (bus.ex_waddr_i != 5'd0);
    assign enq      = ex_acc && (bus.ex_waddr_i != 5'd0) && !ex_win;
    assign deq      = head_win;
    assign win_we   = lsu_win || head_win || ex_win;

    always_comb begin
        win = '0;
        if (lsu_win)       win = '{addr: bus.lsu_waddr_i, data: bus.lsu_wdata_i};
        else if (head_win) win = fifo_mem[rd_ptr];
        else if (ex_win)   win = '{addr: bus.ex_waddr_i, data: bus.ex_wdata_i};
    end

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk_int) begin
        if (enq) fifo_mem[wr_ptr] <= '{addr: bus.ex_waddr_i, data: bus.ex_wdata_i};
    end

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= win_we;
            waddr_q <= win.addr;
            wdata_q <= win.data;
        end
    end

    // Issue applied after writeback clear so a same-cycle set survives.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (bus.lsu_issue_i) pend_set[bus.lsu_issue_waddr_i] = 1'b1;
        if (bus.lsu_valid_i) pend_clr[bus.lsu_waddr_i] = 1'b1;
        pend_nxt = ((pend_q & ~pend_clr) | pend_set) & ~32'd1;
    end

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_nxt;
            if (lsu_win && !pend_q[bus.lsu_waddr_i]) err_q <= 1'b1;
        end
    end

    // Oldest-to-youngest scan so the youngest matching entry overrides; output register lowest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        bus.fwd_hit_a_o  = 1'b0;
        bus.fwd_data_a_o = '0;
        bus.fwd_hit_b_o  = 1'b0;
        bus.fwd_data_b_o = '0;
        idx = '0;
        if (we_q && waddr_q == bus.raddr_a_i) begin
            bus.fwd_hit_a_o  = 1'b1;
            bus.fwd_data_a_o = wdata_q;
        end
        if (we_q && waddr_q == bus.raddr_b_i) begin
            bus.fwd_hit_b_o  = 1'b1;
            bus.fwd_data_b_o = wdata_q;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (fifo_mem[idx].addr == bus.raddr_a_i) begin
                    bus.fwd_hit_a_o  = 1'b1;
                    bus.fwd_data_a_o = fifo_mem[idx].data;
                end
                if (fifo_mem[idx].addr == bus.raddr_b_i) begin
                    bus.fwd_hit_b_o  = 1'b1;
                    bus.fwd_data_b_o = fifo_mem[idx].data;
                end
            end
        end
        if (bus.raddr_a_i == 5'd0) begin
            bus.fwd_hit_a_o  = 1'b0;
            bus.fwd_data_a_o = '0;
        end
        if (bus.raddr_b_i == 5'd0) begin
            bus.fwd_hit_b_o  = 1'b0;
            bus.fwd_data_b_o = '0;
        end
    end

    assign bus.ex_ready_o     = ex_ready;
    assign bus.we_a_o         = we_q;
    assign bus.waddr_a_o      = waddr_q;
    assign bus.wdata_a_o      = wdata_q;
    assign bus.pend_a_o       = pend_q[bus.raddr_a_i];
    assign bus.pend_b_o       = pend_q[bus.raddr_b_i];
    assign bus.protocol_err_o = err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: expected writes are queued as stimulus
// is driven and popped by a monitor whenever the write port fires.
module tb_regfile_wb_arbiter;
    logic clk_int = 1'b0;
    logic rst_n;
    always #5 clk_int = ~clk_int;

    regfile_wb_if #(.DATA_WIDTH(32)) bus ();

    regfile_wb_arbiter #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clk_int (clk_int),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q [$];
    wr_t mon_e;

    always @(negedge clk_int) begin
        if (rst_n === 1'b1 && bus.we_a_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=%h expected no write",
                         bus.waddr_a_o, bus.wdata_a_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.waddr_a_o, bus.wdata_a_o} !== mon_e) begin
                    failures++;
                    $display("FAIL write_order got addr=%0d data=%h expected addr=%0d data=%h",
                             bus.waddr_a_o, bus.wdata_a_o, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_int);
        #1;
    endtask

    task automatic idle();
        bus.ex_valid_i        = 1'b0;
        bus.ex_waddr_i        = '0;
        bus.ex_wdata_i        = '0;
        bus.lsu_valid_i       = 1'b0;
        bus.lsu_waddr_i       = '0;
        bus.lsu_wdata_i       = '0;
        bus.lsu_issue_i       = 1'b0;
        bus.lsu_issue_waddr_i = '0;
        bus.raddr_a_i         = '0;
        bus.raddr_b_i         = '0;
    endtask

    task automatic issue(input logic [4:0] a);
        bus.lsu_issue_i       = 1'b1;
        bus.lsu_issue_waddr_i = a;
        tick();
        bus.lsu_issue_i       = 1'b0;
        bus.lsu_issue_waddr_i = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got %0d writes outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        bus.raddr_a_i = 5'd5;
        bus.raddr_b_i = 5'd5;
        bus.ex_waddr_i = 5'd5;
        repeat (2) tick();
        checks++;
        if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== 38'd0) begin
            failures++;
            $display("FAIL reset_wport got we=%b addr=%0d data=%h expected 0/0/0",
                     bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o);
        end
        checks++;
        if ({bus.ex_ready_o, bus.fwd_hit_a_o, bus.fwd_hit_b_o, bus.pend_a_o, bus.pend_b_o,
             bus.protocol_err_o} !== 6'd0) begin
            failures++;
            $display("FAIL reset_flags got rdy=%b hit=%b%b pend=%b%b err=%b expected all 0",
                     bus.ex_ready_o, bus.fwd_hit_a_o, bus.fwd_hit_b_o, bus.pend_a_o,
                     bus.pend_b_o, bus.protocol_err_o);
        end
        @(negedge clk_int);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.ex_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b expected 1", bus.ex_ready_o);
        end
        idle();
        tick();
    endtask

    task automatic test_ex_only();
        bus.ex_valid_i = 1'b1;
        bus.ex_waddr_i = 5'd5;
        bus.ex_wdata_i = 32'hA5A5_0001;
        exp_q.push_back('{addr: 5'd5, data: 32'hA5A5_0001});
        #1;
        checks++;
        if (bus.ex_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ex_only_ready got %b expected 1", bus.ex_ready_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd5, 32'hA5A5_0001}) begin
            failures++;
            $display("FAIL ex_only_latency got we=%b addr=%0d data=%h expected 1/5/a5a50001",
                     bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o);
        end
        tick();
        checks++;
        if (bus.we_a_o !== 1'b0) begin
            failures++;
            $display("FAIL ex_only_idle_we got %b expected 0", bus.we_a_o);
        end
        wait_drain(4);
    endtask

    task automatic test_collision();
        issue(5'd7);
        bus.raddr_a_i = 5'd7;
        #1;
        checks++;
        if (bus.pend_a_o !== 1'b1) begin
            failures++;
            $display("FAIL coll_pend_set got %b expected 1", bus.pend_a_o);
        end
        bus.lsu_valid_i = 1'b1;
        bus.lsu_waddr_i = 5'd7;
        bus.lsu_wdata_i = 32'h11;
        bus.ex_valid_i  = 1'b1;
        bus.ex_waddr_i  = 5'd3;
        bus.ex_wdata_i  = 32'h22;
        exp_q.push_back('{addr: 5'd7, data: 32'h11});
        exp_q.push_back('{addr: 5'd3, data: 32'h22});
        tick();
        idle();
        bus.raddr_a_i = 5'd7;
        #1;
        checks++;
        if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd7, 32'h11}) begin
            failures++;
            $display("FAIL coll_lsu_first got we=%b addr=%0d data=%h expected 1/7/11",
                     bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o);
        end
        checks++;
        if (bus.pend_a_o !== 1'b0) begin
            failures++;
            $display("FAIL coll_pend_clear got %b expected 0", bus.pend_a_o);
        end
        tick();
        checks++;
        if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o} !== {1'b1, 5'd3, 32'h22}) begin
            failures++;
            $display("FAIL coll_ex_second got we=%b addr=%0d data=%h expected 1/3/22",
                     bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o);
        end
        wait_drain(4);
    endtask

    task automatic test_backpressure();
        logic [4:0]  la [3] = '{5'd10, 5'd11, 5'd13};
        logic [31:0] ld [3] = '{32'hA0, 32'hB0, 32'hD0};
        logic [4:0]  ea [3] = '{5'd1, 5'd2, 5'd6};
        logic [31:0] ed [3] = '{32'h100, 32'h200, 32'h300};
        logic        er [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) issue(la[i]);
        for (int i = 0; i < 3; i++) exp_q.push_back('{addr: la[i], data: ld[i]});
        for (int i = 0; i < 3; i++) exp_q.push_back('{addr: ea[i], data: ed[i]});
        for (int i = 0; i < 3; i++) begin
            bus.lsu_valid_i = 1'b1;
            bus.lsu_waddr_i = la[i];
            bus.lsu_wdata_i = ld[i];
            bus.ex_valid_i  = 1'b1;
            bus.ex_waddr_i  = ea[i];
            bus.ex_wdata_i  = ed[i];
            #1;
            checks++;
            if (bus.ex_ready_o !== er[i]) begin
                failures++;
                $display("FAIL bp_ready_c%0d got %b expected %b", i, bus.ex_ready_o, er[i]);
            end
            tick();
        end
        bus.lsu_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.ex_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_full_draining got %b expected 0", bus.ex_ready_o);
        end
        tick();
        checks++;
        if (bus.ex_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_reassert got %b expected 1", bus.ex_ready_o);
        end
        tick();
        idle();
        wait_drain(12);
    endtask

    task automatic test_hazard();
        issue(5'd9);
        bus.ex_valid_i = 1'b1;
        bus.ex_waddr_i = 5'd9;
        bus.ex_wdata_i = 32'hEE;
        bus.raddr_a_i  = 5'd9;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                bus.lsu_valid_i = 1'b1;
                bus.lsu_waddr_i = 5'd9;
                bus.lsu_wdata_i = 32'h99;
                exp_q.push_back('{addr: 5'd9, data: 32'h99});
                exp_q.push_back('{addr: 5'd9, data: 32'hEE});
            end
            #1;
            checks++;
            if ({bus.ex_ready_o, bus.pend_a_o} !== 2'b01) begin
                failures++;
                $display("FAIL hazard_block_c%0d got rdy=%b pend=%b expected 0/1",
                         i, bus.ex_ready_o, bus.pend_a_o);
            end
            tick();
        end
        bus.lsu_valid_i = 1'b0;
        #1;
        checks++;
        if ({bus.ex_ready_o, bus.pend_a_o} !== 2'b10) begin
            failures++;
            $display("FAIL hazard_release got rdy=%b pend=%b expected 1/0",
                     bus.ex_ready_o, bus.pend_a_o);
        end
        tick();
        idle();
        wait_drain(6);
    endtask

    task automatic test_forward();
        issue(5'd14);
        issue(5'd15);
        exp_q.push_back('{addr: 5'd14, data: 32'h140});
        exp_q.push_back('{addr: 5'd15, data: 32'h150});
        exp_q.push_back('{addr: 5'd4,  data: 32'h1});
        exp_q.push_back('{addr: 5'd4,  data: 32'h2});
        bus.lsu_valid_i = 1'b1;
        bus.lsu_waddr_i = 5'd14;
        bus.lsu_wdata_i = 32'h140;
        bus.ex_valid_i  = 1'b1;
        bus.ex_waddr_i  = 5'd4;
        bus.ex_wdata_i  = 32'h1;
        tick();
        bus.lsu_waddr_i = 5'd15;
        bus.lsu_wdata_i = 32'h150;
        bus.ex_wdata_i  = 32'h2;
        tick();
        idle();
        bus.raddr_a_i = 5'd15;
        bus.raddr_b_i = 5'd4;
        #1;
        checks++;
        if ({bus.fwd_hit_b_o, bus.fwd_data_b_o} !== {1'b1, 32'h2}) begin
            failures++;
            $display("FAIL fwd_youngest got hit=%b data=%h expected 1/2",
                     bus.fwd_hit_b_o, bus.fwd_data_b_o);
        end
        checks++;
        if ({bus.fwd_hit_a_o, bus.fwd_data_a_o} !== {1'b1, 32'h150}) begin
            failures++;
            $display("FAIL fwd_outreg got hit=%b data=%h expected 1/150",
                     bus.fwd_hit_a_o, bus.fwd_data_a_o);
        end
        tick();
        bus.raddr_a_i = 5'd0;
        #1;
        checks++;
        if ({bus.fwd_hit_b_o, bus.fwd_data_b_o, bus.fwd_hit_a_o, bus.fwd_data_a_o} !==
            {1'b1, 32'h2, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL fwd_fifo_over_outreg got b=%b/%h a=%b/%h expected 1/2 0/0",
                     bus.fwd_hit_b_o, bus.fwd_data_b_o, bus.fwd_hit_a_o, bus.fwd_data_a_o);
        end
        tick();
        tick();
        checks++;
        if ({bus.fwd_hit_b_o, bus.fwd_data_b_o} !== 33'd0) begin
            failures++;
            $display("FAIL fwd_no_match got hit=%b data=%h expected 0/0",
                     bus.fwd_hit_b_o, bus.fwd_data_b_o);
        end
        idle();
        wait_drain(4);
    endtask

    task automatic test_x0_err();
        bus.ex_valid_i = 1'b1;
        bus.ex_waddr_i = 5'd0;
        bus.ex_wdata_i = 32'hFFFF;
        #1;
        checks++;
        if (bus.ex_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL x0_ex_ready got %b expected 1", bus.ex_ready_o);
        end
        tick();
        idle();
        bus.lsu_valid_i = 1'b1;
        bus.lsu_waddr_i = 5'd0;
        bus.lsu_wdata_i = 32'h1234;
        #1;
        checks++;
        if (bus.we_a_o !== 1'b0) begin
            failures++;
            $display("FAIL x0_ex_discard got we=%b expected 0", bus.we_a_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({bus.we_a_o, bus.protocol_err_o} !== 2'b00) begin
            failures++;
            $display("FAIL x0_lsu_discard got we=%b err=%b expected 0/0",
                     bus.we_a_o, bus.protocol_err_o);
        end
        bus.lsu_valid_i = 1'b1;
        bus.lsu_waddr_i = 5'd12;
        bus.lsu_wdata_i = 32'hC0;
        exp_q.push_back('{addr: 5'd12, data: 32'hC0});
        tick();
        idle();
        repeat (4) begin
            checks++;
            if (bus.protocol_err_o !== 1'b1) begin
                failures++;
                $display("FAIL err_sticky got %b expected 1", bus.protocol_err_o);
            end
            tick();
        end
        wait_drain(4);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.protocol_err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_reset got %b expected 0", bus.protocol_err_o);
        end
        @(negedge clk_int);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        issue(5'd20);
        issue(5'd22);
        bus.lsu_valid_i = 1'b1;
        bus.lsu_waddr_i = 5'd20;
        bus.lsu_wdata_i = 32'h200;
        bus.ex_valid_i  = 1'b1;
        bus.ex_waddr_i  = 5'd21;
        bus.ex_wdata_i  = 32'h210;
        tick();
        idle();
        bus.raddr_a_i = 5'd22;
        bus.raddr_b_i = 5'd21;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.we_a_o, bus.ex_ready_o, bus.pend_a_o, bus.fwd_hit_b_o} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_clear got we=%b rdy=%b pend=%b hit=%b expected 0000",
                     bus.we_a_o, bus.ex_ready_o, bus.pend_a_o, bus.fwd_hit_b_o);
        end
        @(negedge clk_int);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.ex_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ready got %b expected 1", bus.ex_ready_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.we_a_o !== 1'b0) begin
                failures++;
                $display("FAIL midrst_no_write_c%0d got we=%b expected 0", i, bus.we_a_o);
            end
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_ex_only();
        test_collision();
        test_backpressure();
        test_hazard();
        test_forward();
        test_x0_err();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected got %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of all write/forward data.
REQ-002 Parameter FIFO_DEPTH, default 2, number of buffered EX results (power of two, >=2).
REQ-003 clk_int  in  1  block clock; same gated domain as register-file write port.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ex_valid_i / ex_ready_o  in/out  1/1  EX writeback handshake.
REQ-006 ex_waddr_i / ex_wdata_i  in  5/DATA_WIDTH  EX destination and result.
REQ-007 lsu_valid_i  in  1  load data returning; no ready, always accepted.
REQ-008 lsu_waddr_i / lsu_wdata_i  in  5/DATA_WIDTH  load destination and data.
REQ-009 lsu_issue_i / lsu_issue_waddr_i  in  1/5  load issued, marks destination pending.
REQ-010 we_a_o / waddr_a_o / wdata_a_o  out  1/5/DATA_WIDTH  registered register-file write port.
REQ-011 raddr_a_i / raddr_b_i  in  5/5  decode read addresses.
REQ-012 fwd_hit_a_o, fwd_hit_b_o / fwd_data_a_o, fwd_data_b_o  out  1/DATA_WIDTH  forwarding result per port.
REQ-013 pend_a_o / pend_b_o  out  1/1  read address has outstanding load.
REQ-014 protocol_err_o  out  1  sticky protocol-violation flag.

Function
REQ-015 Arbitration per cycle, one winner: LSU valid > FIFO head > direct EX (only when FIFO empty).
REQ-016 Winner is captured into output register; we_a_o/waddr_a_o/wdata_a_o valid exactly 1 cycle after acceptance.
REQ-017 we_a_o SHALL be 0 in any cycle following a cycle with no winner.
REQ-018 EX accepted when ex_valid_i && ex_ready_o; accepted-but-not-winning EX result enqueued at FIFO tail.
REQ-019 ex_ready_o = FIFO not full AND scoreboard bit of ex_waddr_i clear (combinational).
REQ-020 FIFO full with head draining same cycle: ex_ready_o still 0 (no same-cycle pass-through of full).
REQ-021 EX results leave in acceptance order; a new EX never bypasses a non-empty FIFO.
REQ-022 Any write with address 0 (EX or LSU) accepted and discarded: not enqueued, we_a_o stays 0.
REQ-023 Scoreboard: 32-bit pending vector; lsu_issue_i sets bit lsu_issue_waddr_i (x0 ignored).
REQ-024 LSU writeback clears bit lsu_waddr_i; simultaneous set and clear of same bit: set wins.
REQ-025 pend_a_o/pend_b_o = scoreboard bit of raddr_a_i/raddr_b_i, combinational; x0 always 0.
REQ-026 Forwarding per port: search youngest-first FIFO entries, then output register (when we_a_o=1); first address match hits.
REQ-027 fwd_hit=0 and fwd_data=0 when no match or raddr=0.
REQ-028 protocol_err_o set (sticky until reset) when lsu_valid_i arrives for a non-pending nonzero address.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH, never over/underflows.

Reset
REQ-030 rst_n low asynchronously clears: FIFO pointers/count, scoreboard, output register, protocol_err_o.
REQ-031 During reset: we_a_o=0, waddr_a_o=0, wdata_a_o=0, ex_ready_o=0, fwd_hit_*=0, pend_*=0.
REQ-032 Reset mid-operation discards all buffered and pending writes; no write issued after release until new acceptance.
REQ-033 ex_ready_o reasserts first cycle after rst_n deasserts.

Verification
REQ-034 EX only: ex x5=0xA5A5_0001 cycle 0 -> cycle 1 we_a_o=1, waddr_a_o=5, wdata_a_o=0xA5A5_0001.
REQ-035 Collision: issue load x7; cycle N lsu x7=0x11 and ex x3=0x22 -> N+1 write x7=0x11, N+2 write x3=0x22, x7 pending cleared.
REQ-036 Backpressure: LSU valid 3 consecutive cycles while EX valid -> 2 EX queued, ex_ready_o=0 third cycle, drained in order after LSU stops.
REQ-037 Hazard: issue load x9, ex_waddr_i=9 -> ex_ready_o=0, pend_a_o=1 for raddr_a_i=9 until LSU x9 returns.
REQ-038 Forward: x4=0x1 then x4=0x2 queued behind LSU -> raddr_b_i=4 gives fwd_hit_b_o=1, fwd_data_b_o=0x2.
REQ-039 x0 and error: ex x0=0xFFFF -> no write; lsu x12 not pending -> protocol_err_o=1 until rst_n low.
